// File: rtl/itcm_loader.sv
// Purpose  : packs a little-endian byte stream into DW-bit words and writes them to ITCM, one command at a time.
// Latency  : MW byte cycles + 1 CMD cycle + 1 RSP cycle per word (minimum); done pulses one cycle after the last response.
// Backpress: ld_ready drops while a word is in flight; cmd_addr/cmd_wdata hold until cmd_ready; rsp_ready only in RSP.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ld_start/ld_base/ld_words   load request (sampled in IDLE only)
//   ld_valid/ld_ready/ld_data   byte stream in
//   cmd_*                       write command out (single outstanding)
//   rsp_valid/rsp_ready/rsp_rdata  write response in (rdata ignored)
//   core_hold, busy, done       status
module itcm_loader #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int MW    = DW / 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic [AW-1:0]    ld_base,
    input  logic [CNT_W-1:0] ld_words,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [7:0]       ld_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_read,
    output logic [AW-1:0]    cmd_addr,
    output logic [DW-1:0]    cmd_wdata,
    output logic [MW-1:0]    cmd_wmask,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [DW-1:0]    rsp_rdata,
    output logic             core_hold,
    output logic             busy,
    output logic             done
);

    localparam int IW = (MW > 1) ? $clog2(MW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CMD,
        S_RSP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [IW-1:0]    r_idx;
    logic [CNT_W-1:0] r_remain;

    logic w_byte_acc;
    logic w_last_byte;
    logic w_unused_rdata;

    assign w_byte_acc     = ld_valid & ld_ready;
    assign w_last_byte    = (r_idx == IW'(MW - 1));
    assign w_unused_rdata = ^rsp_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ld_start) w_next = (ld_words != '0) ? S_COLLECT : S_DONE;
            end
            S_COLLECT: begin
                if (w_byte_acc && w_last_byte) w_next = S_CMD;
            end
            S_CMD: begin
                if (cmd_ready) w_next = S_RSP;
            end
            S_RSP: begin
                // r_remain still holds the pre-decrement count here
                if (rsp_valid) w_next = (r_remain == CNT_W'(1)) ? S_DONE : S_COLLECT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address / data / counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_idx    <= '0;
            r_remain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ld_start && ld_words != '0) begin
                        // force word alignment: drop the byte-lane bits of the base
                        r_addr   <= ld_base & ~AW'(MW - 1);
                        r_remain <= ld_words;
                        r_idx    <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_byte_acc) begin
                        r_wdata[8*r_idx +: 8] <= ld_data;
                        r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_valid) begin
                        r_remain <= r_remain - 1'b1;
                        r_addr   <= r_addr + AW'(MW);   // wraps modulo 2^AW
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_ready  = (r_state == S_COLLECT);
    assign cmd_valid = (r_state == S_CMD);
    assign cmd_read  = 1'b0;
    assign cmd_addr  = r_addr;
    assign cmd_wdata = r_wdata;
    assign cmd_wmask = cmd_valid ? {MW{1'b1}} : '0;
    assign rsp_ready = (r_state == S_RSP);
    assign busy      = (r_state != S_IDLE);
    assign core_hold = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_itcm_loader.sv
module tb_itcm_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_words;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        core_hold;
    logic        busy;
    logic        done;

    itcm_loader dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_base(ld_base), .ld_words(ld_words),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .core_hold(core_hold), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cmd_cnt  = 0;
    int done_cnt = 0;

    // scoreboard entries: {addr[15:0], wdata[31:0]}
    logic [47:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command monitor: pops expected word on every accepted command
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            cmd_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_cmd", 64'(cmd_addr), 64'hDEAD);
            end else begin
                logic [47:0] e;
                e = sb.pop_front();
                chk("cmd_addr",  64'(cmd_addr),  64'(e[47:32]));
                chk("cmd_wdata", 64'(cmd_wdata), 64'(e[31:0]));
                chk("cmd_wmask", 64'(cmd_wmask), 64'hF);
                chk("cmd_read",  64'(cmd_read),  64'h0);
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic start(input logic [15:0] base, input logic [15:0] words);
        ld_start = 1'b1;
        ld_base  = base;
        ld_words = words;
        @(posedge clk); #1;
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        ld_valid = 1'b1;
        ld_data  = b;
        n = 0;
        @(negedge clk);
        while (!ld_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("byte_timeout", 64'(n < 100), 64'h1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 200), 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld_ready"},  64'(ld_ready),  64'h0);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'h0);
        chk({tag, "_rsp_ready"}, 64'(rsp_ready), 64'h0);
        chk({tag, "_core_hold"}, 64'(core_hold), 64'h0);
        chk({tag, "_busy"},      64'(busy),      64'h0);
        chk({tag, "_done"},      64'(done),      64'h0);
        chk({tag, "_cmd_addr"},  64'(cmd_addr),  64'h0);
        chk({tag, "_cmd_wdata"}, 64'(cmd_wdata), 64'h0);
        chk({tag, "_cmd_wmask"}, 64'(cmd_wmask), 64'h0);
    endtask

    initial begin
        int d0;
        int c0;
        rst = 1'b1; ld_start = 1'b0; ld_base = '0; ld_words = '0;
        ld_valid = 1'b0; ld_data = '0; cmd_ready = 1'b1; rsp_valid = 1'b1;
        rsp_rdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: two words, handshakes always ready
        d0 = done_cnt;
        sb.push_back({16'h0010, 32'h44332211});
        sb.push_back({16'h0014, 32'h88776655});
        start(16'h0010, 16'd2);
        chk("t1_core_hold", 64'(core_hold), 64'h1);
        send_word(32'h44332211);
        send_word(32'h88776655);
        wait_idle();
        chk("t1_done_once", 64'(done_cnt - d0), 64'h1);
        chk("t1_sb_empty", 64'(sb.size()), 64'h0);

        // 2: unaligned base, low bits ignored
        sb.push_back({16'h0010, 32'h04030201});
        start(16'h0013, 16'd1);
        send_word(32'h04030201);
        wait_idle();
        chk("t2_sb_empty", 64'(sb.size()), 64'h0);

        // 3: cmd_ready stalled for 5 cycles while the next byte is offered
        cmd_ready = 1'b0;
        sb.push_back({16'h0100, 32'hA3A2A1A0});
        sb.push_back({16'h0104, 32'hB3B2B1B0});
        start(16'h0100, 16'd2);
        send_word(32'hA3A2A1A0);
        ld_valid = 1'b1;
        ld_data  = 8'hB0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_cmd_valid", 64'(cmd_valid), 64'h1);
            chk("t3_stall_cmd_addr",  64'(cmd_addr),  64'h0100);
            chk("t3_stall_cmd_wdata", 64'(cmd_wdata), 64'hA3A2A1A0);
            chk("t3_stall_ld_ready",  64'(ld_ready),  64'h0);
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        send_word(32'hB3B2B1B0);
        wait_idle();
        chk("t3_sb_empty", 64'(sb.size()), 64'h0);

        // 4: zero-word load: done only, no command
        c0 = cmd_cnt;
        d0 = done_cnt;
        chk("t4_hold_before", 64'(core_hold), 64'h0);
        start(16'h0040, 16'd0);
        chk("t4_done",      64'(done),      64'h1);
        chk("t4_core_hold", 64'(core_hold), 64'h1);
        chk("t4_cmd_valid", 64'(cmd_valid), 64'h0);
        @(posedge clk); #1;
        chk("t4_done_after", 64'(done),      64'h0);
        chk("t4_hold_after", 64'(core_hold), 64'h0);
        chk("t4_no_cmd",     64'(cmd_cnt - c0),  64'h0);
        chk("t4_done_once",  64'(done_cnt - d0), 64'h1);

        // 5: address wrap at top of the 16-bit space
        sb.push_back({16'hFFFC, 32'hDDCCBBAA});
        sb.push_back({16'h0000, 32'h11223344});
        start(16'hFFFC, 16'd2);
        send_word(32'hDDCCBBAA);
        send_word(32'h11223344);
        wait_idle();
        chk("t5_sb_empty", 64'(sb.size()), 64'h0);

        // 6: reset mid-word, then clean restart at a new base
        start(16'h0200, 16'd2);
        send_byte(8'h5A);
        send_byte(8'h5B);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("t6_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        sb.push_back({16'h0300, 32'h0D0C0B0A});
        start(16'h0300, 16'd1);
        send_word(32'h0D0C0B0A);
        wait_idle();
        chk("t6_sb_empty", 64'(sb.size()), 64'h0);
        chk("total_cmds", 64'(cmd_cnt), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
